// File: rtl/uart_rx_if.sv
// Receive-side bundle for uart_rx: baud tick and serial line in,
// received byte with its valid/error strobes and busy flag out.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 tick;
    logic                 rx_line;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 rx_busy;

    modport master (
        input  tick,
        input  rx_line,
        output rx_data,
        output rx_valid,
        output frame_err,
        output rx_busy
    );

    modport slave (
        output tick,
        output rx_line,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled on a shared baud tick.
// Samples mid-bit and flags a bad stop bit as a framing error.
module uart_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q;
    logic                 rx_s_q;
    logic [3:0]           ticks_q, ticks_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 armed_q, armed_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 rx_busy_q, rx_busy_d;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    always_comb begin
        state_d     = state_q;
        ticks_d     = ticks_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        armed_d     = armed_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        rx_busy_d   = rx_busy_q;

        case (state_q)
            IDLE: begin
                rx_busy_d = 1'b0;
                if (bus.tick) begin
                    if (rx_s_q) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        ticks_d   = 4'd0;
                        rx_busy_d = 1'b1;
                        state_d   = START;
                    end
                end
            end
            START: begin
                if (bus.tick) begin
                    if (ticks_q == 4'd7) begin
                        if (rx_s_q) begin
                            // glitch, not a start bit; stay armed
                            rx_busy_d = 1'b0;
                            state_d   = IDLE;
                        end else begin
                            ticks_d   = 4'd0;
                            bit_idx_d = 3'd0;
                            state_d   = DATA;
                        end
                    end else begin
                        ticks_d = ticks_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (bus.tick) begin
                    if (ticks_q == 4'd15) begin
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        ticks_d = 4'd0;
                        if (bit_idx_q == LAST_BIT) begin
                            state_d = STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        ticks_d = ticks_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (bus.tick) begin
                    if (ticks_q == 4'd15) begin
                        rx_data_d = shift_q;
                        rx_busy_d = 1'b0;
                        state_d   = IDLE;
                        if (rx_s_q) begin
                            rx_valid_d = 1'b1;
                        end else begin
                            // disarm so a held-low break yields one error only
                            frame_err_d = 1'b1;
                            armed_d     = 1'b0;
                        end
                    end else begin
                        ticks_d = ticks_q + 4'd1;
                    end
                end
            end
            default: begin
                rx_busy_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            ticks_q     <= 4'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= '0;
            armed_q     <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= bus.rx_line;
            rx_s_q      <= rx_meta_q;
            ticks_q     <= ticks_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            armed_q     <= armed_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            rx_busy_q   <= rx_busy_d;
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.rx_busy   = rx_busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives 8N1 frames at 16 ticks/bit,
// tick every 4 clk, and checks strobes, data and busy timing.
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(.DATA_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    int tdiv = 0;
    initial bus.tick = 1'b0;
    always @(negedge clk) begin
        bus.tick = (tdiv == 3);
        tdiv = (tdiv + 1) % 4;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    int         both      = 0;
    int         wide      = 0;
    int         busy_bad  = 0;
    logic       busy_seen = 1'b0;
    logic [7:0] ferr_data = 8'h00;
    logic [7:0] got[$];
    int         vcyc[$];
    logic       prev_valid = 1'b0;
    logic       prev_ferr  = 1'b0;
    logic       prev_busy  = 1'b0;

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            valid_cnt++;
            got.push_back(bus.rx_data);
            vcyc.push_back(cyc);
            if (!prev_busy || bus.rx_busy) busy_bad++;
        end
        if (bus.frame_err) begin
            ferr_cnt++;
            ferr_data = bus.rx_data;
        end
        if (bus.rx_valid && bus.frame_err) both++;
        if ((bus.rx_valid && prev_valid) || (bus.frame_err && prev_ferr))
            wide++;
        if (bus.rx_busy) busy_seen = 1'b1;
        prev_valid = bus.rx_valid;
        prev_ferr  = bus.frame_err;
        prev_busy  = bus.rx_busy;
    end

    task automatic drive_bit(input logic b, input int nticks);
        bus.rx_line = b;
        repeat (nticks * 4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
        drive_bit(stop, 16);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.rx_line = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h want 00", bus.rx_data);
        end
        checks++;
        if (bus.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", bus.rx_valid);
        end
        checks++;
        if (bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ferr: got %b want 0", bus.frame_err);
        end
        checks++;
        if (bus.rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", bus.rx_busy);
        end
        rst = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_basic();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1);
        drive_bit(1'b1, 8);
        checks++;
        if (valid_cnt !== v0 + 1) begin
            errors++;
            $display("FAIL basic_count: got %0d want %0d", valid_cnt, v0 + 1);
        end
        checks++;
        if (bus.rx_data !== 8'hA5) begin
            errors++;
            $display("FAIL basic_data: got %h want a5", bus.rx_data);
        end
        checks++;
        if (ferr_cnt !== f0) begin
            errors++;
            $display("FAIL basic_ferr: got %0d want %0d", ferr_cnt, f0);
        end
        checks++;
        if (busy_bad !== 0) begin
            errors++;
            $display("FAIL basic_busy_fall: got %0d want 0", busy_bad);
        end
        checks++;
        if (wide !== 0) begin
            errors++;
            $display("FAIL basic_pulse_width: got %0d want 0", wide);
        end
    endtask

    task automatic test_false_start();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        busy_seen = 1'b0;
        drive_bit(1'b0, 5);
        drive_bit(1'b1, 20);
        checks++;
        if (busy_seen !== 1'b1) begin
            errors++;
            $display("FAIL false_busy_seen: got %b want 1", busy_seen);
        end
        checks++;
        if (valid_cnt !== v0 || ferr_cnt !== f0) begin
            errors++;
            $display("FAIL false_strobe: got v=%0d f=%0d want v=%0d f=%0d",
                     valid_cnt, ferr_cnt, v0, f0);
        end
        checks++;
        if (bus.rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL false_idle: got busy %b want 0", bus.rx_busy);
        end
        send_frame(8'h3C, 1'b1);
        drive_bit(1'b1, 8);
        checks++;
        if (valid_cnt !== v0 + 1 || bus.rx_data !== 8'h3C) begin
            errors++;
            $display("FAIL false_next: got n=%0d d=%h want n=%0d d=3c",
                     valid_cnt, bus.rx_data, v0 + 1);
        end
    endtask

    task automatic test_frame_err();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        drive_bit(1'b0, 40);
        checks++;
        if (ferr_cnt !== f0 + 1) begin
            errors++;
            $display("FAIL ferr_count: got %0d want %0d", ferr_cnt, f0 + 1);
        end
        checks++;
        if (ferr_data !== 8'h3C) begin
            errors++;
            $display("FAIL ferr_data: got %h want 3c", ferr_data);
        end
        checks++;
        if (valid_cnt !== v0) begin
            errors++;
            $display("FAIL ferr_no_valid: got %0d want %0d", valid_cnt, v0);
        end
        checks++;
        if (bus.rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL ferr_break_idle: got busy %b want 0", bus.rx_busy);
        end
        drive_bit(1'b1, 4);
        send_frame(8'h81, 1'b1);
        drive_bit(1'b1, 8);
        checks++;
        if (valid_cnt !== v0 + 1 || bus.rx_data !== 8'h81) begin
            errors++;
            $display("FAIL ferr_recover: got n=%0d d=%h want n=%0d d=81",
                     valid_cnt, bus.rx_data, v0 + 1);
        end
        checks++;
        if (ferr_cnt !== f0 + 1) begin
            errors++;
            $display("FAIL ferr_single: got %0d want %0d", ferr_cnt, f0 + 1);
        end
    endtask

    task automatic test_back_to_back();
        int v0 = valid_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        drive_bit(1'b1, 8);
        checks++;
        if (valid_cnt !== v0 + 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d want %0d", valid_cnt, v0 + 3);
        end
        checks++;
        if (got[v0] !== 8'h00) begin
            errors++;
            $display("FAIL b2b_data0: got %h want 00", got[v0]);
        end
        checks++;
        if (got[v0+1] !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_data1: got %h want ff", got[v0+1]);
        end
        checks++;
        if (got[v0+2] !== 8'h55) begin
            errors++;
            $display("FAIL b2b_data2: got %h want 55", got[v0+2]);
        end
        checks++;
        if (vcyc[v0+1] - vcyc[v0] !== 640) begin
            errors++;
            $display("FAIL b2b_gap1: got %0d clk want 640",
                     vcyc[v0+1] - vcyc[v0]);
        end
        checks++;
        if (vcyc[v0+2] - vcyc[v0+1] !== 640) begin
            errors++;
            $display("FAIL b2b_gap2: got %0d clk want 640",
                     vcyc[v0+2] - vcyc[v0+1]);
        end
    endtask

    task automatic test_reset_mid();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        logic [7:0] d = 8'hC3;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) drive_bit(d[i], 16);
        drive_bit(d[3], 8);
        checks++;
        if (bus.rx_busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy_before: got %b want 1", bus.rx_busy);
        end
        rst = 1'b1;
        bus.rx_line = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rx_data !== 8'h00 || bus.rx_valid !== 1'b0 ||
            bus.frame_err !== 1'b0 || bus.rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: got d=%h v=%b f=%b b=%b want 0",
                     bus.rx_data, bus.rx_valid, bus.frame_err, bus.rx_busy);
        end
        rst = 1'b0;
        drive_bit(1'b1, 20);
        checks++;
        if (valid_cnt !== v0 || ferr_cnt !== f0) begin
            errors++;
            $display("FAIL rstmid_no_strobe: got v=%0d f=%0d want v=%0d f=%0d",
                     valid_cnt, ferr_cnt, v0, f0);
        end
        send_frame(8'h7E, 1'b1);
        drive_bit(1'b1, 8);
        checks++;
        if (valid_cnt !== v0 + 1 || bus.rx_data !== 8'h7E) begin
            errors++;
            $display("FAIL rstmid_next: got n=%0d d=%h want n=%0d d=7e",
                     valid_cnt, bus.rx_data, v0 + 1);
        end
    endtask

    task automatic test_loopback();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        drive_bit(1'b1, 16);
        send_frame(8'h5A, 1'b1);
        send_frame(8'h01, 1'b1);
        drive_bit(1'b1, 16);
        checks++;
        if (valid_cnt !== v0 + 2) begin
            errors++;
            $display("FAIL loop_count: got %0d want %0d", valid_cnt, v0 + 2);
        end
        checks++;
        if (got[v0] !== 8'h5A || got[v0+1] !== 8'h01) begin
            errors++;
            $display("FAIL loop_data: got %h %h want 5a 01",
                     got[v0], got[v0+1]);
        end
        checks++;
        if (ferr_cnt !== f0) begin
            errors++;
            $display("FAIL loop_ferr: got %0d want %0d", ferr_cnt, f0);
        end
    endtask

    task automatic test_strobe_rules();
        checks++;
        if (both !== 0) begin
            errors++;
            $display("FAIL strobe_overlap: got %0d want 0", both);
        end
        checks++;
        if (wide !== 0) begin
            errors++;
            $display("FAIL strobe_width: got %0d want 0", wide);
        end
        checks++;
        if (busy_bad !== 0) begin
            errors++;
            $display("FAIL busy_fall: got %0d want 0", busy_bad);
        end
    endtask

    initial begin
        bus.rx_line = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_loopback();
        test_strobe_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

8N1 UART receiver. It recovers frames of one start bit (0), DATA_BITS data bits LSB-first and one stop bit (1) from the serial line, using the shared 16x-oversampling baud `tick`. It presents each received byte with a one-cycle valid strobe and flags framing errors. It sits opposite `uart_tx` on the serial link and is driven by the same baud tick generator; in loopback, `rx_line` is wired to `tx_line`.

## Interface
- DATA_BITS, 8: data bits per frame. Oversampling is fixed at 16 ticks per bit.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- tick  in  1  one-clk-wide enable pulse at 16x baud rate.
- rx_line  in  1  asynchronous serial input; idles high.
- rx_data  out  DATA_BITS  last received byte; held until the next frame completes.
- rx_valid  out  1  one-clk pulse: rx_data is updated and the stop bit was good.
- frame_err  out  1  one-clk pulse: the stop bit was sampled low.
- rx_busy  out  1  high from start-bit detection until return to IDLE.

## Operation
- Input conditioning: `rx_line` passes through a 2-flop synchronizer (reset value 1) to give `rx_s`. All decisions use `rx_s` only.
- Internal registers:
  - `ticks_cnt`, 4 bits
  - `bit_idx`, 3 bits
  - `shift_reg`, DATA_BITS
  - `armed`, 1 bit
- **IDLE**
  - rx_busy=0.
  - On a tick with `rx_s`=1, set armed=1.
  - On a tick with armed=1 and `rx_s`=0: ticks_cnt←0, rx_busy←1, go to START.
- **START** (runs on ticks only)
  - At ticks_cnt==7 (mid start bit):
    - `rx_s`=1 → false start; go to IDLE with armed still 1. No strobe.
    - `rx_s`=0 → ticks_cnt←0, bit_idx←0, go to DATA.
  - Otherwise, ticks_cnt increments.
- **DATA** (runs on ticks only)
  - At ticks_cnt==15 (mid data bit): shift_reg←{rx_s, shift_reg[DATA_BITS-1:1]}, ticks_cnt←0.
  - If bit_idx==DATA_BITS-1, go to STOP; else bit_idx increments.
  - Otherwise, ticks_cnt increments.
- **STOP** (runs on ticks only)
  - At ticks_cnt==15 (mid stop bit): rx_data←shift_reg.
    - `rx_s`=1 → rx_valid pulses, armed stays 1.
    - `rx_s`=0 → frame_err pulses, armed←0.
    - Either way, go to IDLE.
  - Otherwise, ticks_cnt increments.
- rx_data is updated on frame_err as well as on rx_valid. A consumer must qualify it with rx_valid.
- Clearing `armed` on a framing error stops a held-low line (break) from producing repeated frames. Reception resumes only after `rx_s` is seen high on a tick.
- Any state encoding outside the four states returns to IDLE on the next clk.
- Clk edges with no tick change nothing except the synchronizer and the strobe clearing.

## Timing
- Reset values: rx_data=0, rx_valid=0, frame_err=0, rx_busy=0, state=IDLE, armed=1, counters 0, synchronizer flops 1.
- Reset mid-frame: on the next clk, all values return to reset state. No strobe is issued for the partial frame.
- rx_valid and frame_err are high for exactly one clk: the clk after the tick that samples the stop bit. They are never high together.
- Synchronizer latency is 2 clk. Given a tick period ≥ 3 clk, start detection lags the line edge by at most 1 tick plus 2 clk.
- Sample points, measured in ticks after the detected falling edge:
  - start check at 8
  - data bit k at 24+16k
  - stop at 24+16·DATA_BITS (152 for 8 bits)
- Back-to-back frames: IDLE is re-entered at mid stop bit, so a start bit that immediately follows the stop bit is detected without loss.
- No back-pressure. A consumer that misses rx_valid loses the byte; the next frame overwrites rx_data.

## Test plan
- Frame 0xA5 at 16 ticks/bit, tick every 4 clk → rx_data=0xA5, rx_valid high for 1 clk, frame_err=0, rx_busy falls in the same cycle.
- Line low for 5 ticks, then high → no rx_valid and no frame_err; rx_busy pulses, then IDLE. A following 0x3C frame is received correctly.
- Frame 0x3C with stop bit 0, line then held low for 40 ticks → one frame_err pulse, rx_data=0x3C, no rx_valid, no second frame. After the line goes high, 0x81 is received.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap → three rx_valid pulses, each 160 ticks apart, with data in order.
- Assert rst during DATA bit 3 of 0xC3 → all outputs 0 the next clk. A subsequent 0x7E frame is received correctly.
- Loopback from uart_tx sending 0x5A, then 0x01 → rx_valid twice, with rx_data 0x5A then 0x01 and no frame_err.
